uart_echo_tester: RTL

- Host-side initiator for the UART echo path: transmits a byte sequence on its txd, receives the echoed bytes on its rxd, and compares each echo against the byte sent.
- Used as the far-end partner of the board's 115200 bps echo design, both on the bench and as an on-chip self-test master.
- Self-contained 8N1 transmitter and receiver plus a control FSM.
- Reports per-run error count, timeout flag and last received byte.

---
 rtl/uart_echo_tester.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_tester.sv
// UART echo initiator: sends a byte pattern over an 8N1 link and checks the echoed bytes.
// Define UART_ECHO_TESTER_PRBS_EN for a PRBS-8 pattern instead of the incrementing one.
module uart_echo_tester #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_count,
  input  logic [7:0] seed,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt,
  output logic       timeout_flag,
  output logic [7:0] last_rx
);

  localparam int unsigned BIT_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV = BIT_DIV / 2;
  localparam int unsigned DIV_W    = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned TMO_W    = (TIMEOUT_BITS > 2) ? $clog2(TIMEOUT_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(HALF_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ECHO,
    CHECK,
    DONE
  } state_e;

  // receiver state
  logic             rx_meta_q, rx_sync_q, rx_prev_q, rx_act_q;
  logic [DIV_W-1:0] rx_div_q;
  logic [3:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_good_q, rx_ferr_q;
  logic [7:0]       rx_byte_q;

  // control / transmitter state
  state_e           state_q;
  logic             txd_q;
  logic [8:0]       tx_shift_q;
  logic [DIV_W-1:0] tx_div_q;
  logic [3:0]       tx_bit_q;
  logic [DIV_W-1:0] tmo_div_q;
  logic [TMO_W-1:0] tmo_bits_q;
  logic [7:0]       remain_q;
  logic [7:0]       pat_q;
  logic [7:0]       hold_q;
  logic             hold_vld_q;
  logic             busy_q, done_q, tmo_flag_q;
  logic [7:0]       err_q;
  logic [7:0]       last_rx_q;

  logic [7:0]       next_pat_d;
  logic [7:0]       first_pat_c;
  logic [7:0]       err_cnt_d;
  logic [2:0]       err_inc_c;
  logic [8:0]       err_sum_c;
  logic             tmo_evt_c, mis_evt_c, ferr_evt_c, ovr_evt_c, advance_c;

  // 8N1 receiver: centre-sampled, returns to idle right after the stop sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_good_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_good_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      if (!rx_act_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_act_q <= 1'b1;
          rx_div_q <= HALF_M1;
          rx_bit_q <= 4'd0;
        end
      end else if (rx_div_q != '0) begin
        rx_div_q <= rx_div_q - 1'b1;
      end else begin
        rx_div_q <= DIV_MAX;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q) rx_act_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_act_q  <= 1'b0;
          rx_good_q <= rx_sync_q;
          rx_ferr_q <= !rx_sync_q;
          rx_byte_q <= rx_shift_q;
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  always_comb begin
    next_pat_d  = pat_q;
    first_pat_c = seed;
`ifdef UART_ECHO_TESTER_PRBS_EN
    next_pat_d  = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
    first_pat_c = (seed == 8'h00) ? 8'h01 : seed;
`else
    next_pat_d  = pat_q + 8'd1;
`endif
  end

  // error events may coincide; each adds one, total saturates at 255
  always_comb begin
    tmo_evt_c  = (state_q == WAIT_ECHO) && !hold_vld_q &&
                 (tmo_div_q == DIV_MAX) && (tmo_bits_q == TMO_MAX);
    mis_evt_c  = (state_q == CHECK) && (hold_q != pat_q);
    ferr_evt_c = busy_q && rx_ferr_q;
    ovr_evt_c  = busy_q && rx_good_q && hold_vld_q;
    advance_c  = tmo_evt_c || (state_q == CHECK);
    err_inc_c  = 3'(tmo_evt_c) + 3'(mis_evt_c) + 3'(ferr_evt_c) + 3'(ovr_evt_c);
    err_sum_c  = {1'b0, err_q} + {6'd0, err_inc_c};
    err_cnt_d  = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      txd_q      <= 1'b1;
      tx_shift_q <= '1;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tmo_div_q  <= '0;
      tmo_bits_q <= '0;
      remain_q   <= '0;
      pat_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      err_q      <= '0;
      last_rx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_cnt_d;
      if (rx_good_q) begin
        last_rx_q <= rx_byte_q;
        if (busy_q && !hold_vld_q) begin
          hold_q     <= rx_byte_q;
          hold_vld_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            remain_q   <= byte_count;
            pat_q      <= first_pat_c;
            err_q      <= '0;
            tmo_flag_q <= 1'b0;
            hold_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            if (byte_count == 8'd0) begin
              state_q <= DONE;
            end else begin
              state_q    <= SEND;
              txd_q      <= 1'b0;
              tx_shift_q <= {1'b1, first_pat_c};
              tx_div_q   <= '0;
              tx_bit_q   <= 4'd0;
            end
          end
        end
        SEND: begin
          if (tx_div_q == DIV_MAX) begin
            tx_div_q <= '0;
            if (tx_bit_q == 4'd9) begin
              state_q    <= WAIT_ECHO;
              tmo_div_q  <= '0;
              tmo_bits_q <= '0;
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end
          end else begin
            tx_div_q <= tx_div_q + 1'b1;
          end
        end
        WAIT_ECHO: begin
          if (hold_vld_q) begin
            state_q <= CHECK;
          end else if (tmo_div_q == DIV_MAX) begin
            tmo_div_q  <= '0;
            tmo_bits_q <= tmo_bits_q + 1'b1;
          end else begin
            tmo_div_q <= tmo_div_q + 1'b1;
          end
          if (tmo_evt_c) tmo_flag_q <= 1'b1;
        end
        CHECK: hold_vld_q <= 1'b0;
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // next byte goes straight out, no idle gap
      if (advance_c) begin
        remain_q <= remain_q - 8'd1;
        if (remain_q == 8'd1) begin
          state_q <= DONE;
        end else begin
          pat_q      <= next_pat_d;
          state_q    <= SEND;
          txd_q      <= 1'b0;
          tx_shift_q <= {1'b1, next_pat_d};
          tx_div_q   <= '0;
          tx_bit_q   <= 4'd0;
        end
      end
    end
  end

  assign uart_txd     = txd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_cnt      = err_q;
  assign timeout_flag = tmo_flag_q;
  assign last_rx      = last_rx_q;

endmodule
